// File: rtl/bound_flasher.sv
// ---------------------------------------------------------------------------
// bound_flasher
//
// Sixteen-lamp bounded flasher. One flick request starts a fixed lamp
// sequence: fill up to lamp 15, drain to lamp 5, fill to lamp 10, drain to
// empty, fill to lamp 5, drain to empty, then idle. The lit lamps always form
// a contiguous run from bit 0 upward. Exactly one lamp changes per edge
// outside IDLE.
//
// Optional feature macro: BOUND_FLASHER_KICKBACK_EN
//   When defined, a flick seen while filling can restart a phase:
//     - In UP15, on the edge that reaches 0x003F or 0x07FF, the bar drains
//       to empty (KB0) and then refills from lamp 0 (UP15).
//     - In UP10, on the edge that reaches 0x07FF, the bar drains back to
//       0x001F (DN5) and fills to 0x07FF again.
//   When undefined, flick is honoured only in IDLE and KB0 does not exist.
//
// Ports:
//   flick  in   1  start / kickback request, level-sampled each rising edge
//   clk    in   1  clock, rising edge active
//   rst_n  in   1  synchronous reset, ACTIVE HIGH (name kept for legacy
//                  reasons); forces IDLE and LED = 0
//   LED    out 16  registered lamp states, bit i = lamp i (1 = on)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bound_flasher (
    input  logic        flick,
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] LED
);

`ifdef BOUND_FLASHER_KICKBACK_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP15 = 3'd1,
        S_DN5  = 3'd2,
        S_UP10 = 3'd3,
        S_DN0  = 3'd4,
        S_UP5  = 3'd5,
        S_DN0E = 3'd6,
        S_KB0  = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP15 = 3'd1,
        S_DN5  = 3'd2,
        S_UP10 = 3'd3,
        S_DN0  = 3'd4,
        S_UP5  = 3'd5,
        S_DN0E = 3'd6
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] led_q, led_d;
    logic [15:0] led_on;
    logic [15:0] led_off;

    // The two possible moves of the bar: light the next lamp up, or
    // extinguish the current top lamp.
    assign led_on  = {led_q[14:0], 1'b1};
    assign led_off = {1'b0, led_q[15:1]};

    // Transitions compare against the value being produced on this edge,
    // so each peak/trough is entered and left on consecutive edges.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        case (state_q)
            S_IDLE: begin
                led_d = 16'h0000;
                if (flick) begin
                    led_d   = 16'h0001;
                    state_d = S_UP15;
                end
            end
            S_UP15: begin
                led_d = led_on;
                if (led_on == 16'hFFFF) begin
                    state_d = S_DN5;
                end
`ifdef BOUND_FLASHER_KICKBACK_EN
                if (flick && (led_on == 16'h003F || led_on == 16'h07FF)) begin
                    state_d = S_KB0;
                end
`endif
            end
            S_DN5: begin
                led_d = led_off;
                if (led_off == 16'h001F) begin
                    state_d = S_UP10;
                end
            end
            S_UP10: begin
                led_d = led_on;
                if (led_on == 16'h07FF) begin
`ifdef BOUND_FLASHER_KICKBACK_EN
                    state_d = flick ? S_DN5 : S_DN0;
`else
                    state_d = S_DN0;
`endif
                end
            end
            S_DN0: begin
                led_d = led_off;
                if (led_off == 16'h0000) begin
                    state_d = S_UP5;
                end
            end
            S_UP5: begin
                led_d = led_on;
                if (led_on == 16'h003F) begin
                    state_d = S_DN0E;
                end
            end
            S_DN0E: begin
                led_d = led_off;
                if (led_off == 16'h0000) begin
                    state_d = S_IDLE;
                end
            end
`ifdef BOUND_FLASHER_KICKBACK_EN
            S_KB0: begin
                led_d = led_off;
                if (led_off == 16'h0000) begin
                    state_d = S_UP15;
                end
            end
`endif
            default: begin
                // Unreachable encodings recover to a clean idle.
                led_d   = 16'h0000;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            led_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_bound_flasher.sv
// ---------------------------------------------------------------------------
// tb_bound_flasher
//
// Directed bench for bound_flasher. Expected lamp values are walked by the
// bench itself (fill = shift left inserting 1, drain = shift right) and
// compared against LED one edge at a time. Kickback scenarios check the
// restart behaviour when BOUND_FLASHER_KICKBACK_EN is defined and check that
// the same flick pulses are ignored when it is not.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bound_flasher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flick;
    logic [15:0] LED;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_led;

    bound_flasher dut (
        .flick (flick),
        .clk   (clk),
        .rst_n (rst_n),
        .LED   (LED)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] e);
        n_assert++;
        assert (LED === e)
        else begin
            n_fail++;
            $error("FAIL %s: LED=%h expected %h", tag, LED, e);
        end
    endtask

    // Advance one edge, sample 1 ns later, compare with exp_led.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        chk(tag, exp_led);
        $display("edge %-16s flick=%b rst=%b LED=%h exp=%h", tag, flick, rst_n, LED, exp_led);
    endtask

    task automatic up_to(input string tag, input logic [15:0] tgt);
        for (int i = 0; i < 16 && exp_led != tgt; i++) begin
            exp_led = {exp_led[14:0], 1'b1};
            step(tag);
        end
    endtask

    task automatic down_to(input string tag, input logic [15:0] tgt);
        for (int i = 0; i < 16 && exp_led != tgt; i++) begin
            exp_led = {1'b0, exp_led[15:1]};
            step(tag);
        end
    endtask

    task automatic start_seq(input string tag);
        flick   = 1'b1;
        exp_led = 16'h0001;
        step(tag);
        flick   = 1'b0;
    endtask

    initial begin
        flick   = 1'b0;
        rst_n   = 1'b1;
        exp_led = 16'h0000;

        // Reset, then idle with flick low.
        step("reset");
        rst_n = 1'b0;
        repeat (50) step("idle_hold");

        // Single pulse: nominal 56-edge sequence.
        start_seq("start");
        up_to("up15", 16'hFFFF);
        down_to("dn5", 16'h001F);
        up_to("up10", 16'h07FF);
        down_to("dn0", 16'h0000);
        up_to("up5", 16'h003F);
        down_to("dn0e", 16'h0000);
        repeat (5) step("idle_after");

        // Flick held during DN5/UP10 (not on the 0x07FF edge), DN0/UP5/DN0E.
        start_seq("start2");
        up_to("up15_b", 16'hFFFF);
        down_to("dn5_b", 16'h7FFF);
        flick = 1'b1;
        down_to("dn5_flick", 16'h001F);
        up_to("up10_flick", 16'h03FF);
        flick = 1'b0;
        up_to("up10_b", 16'h07FF);
        flick = 1'b1;
        down_to("dn0_flick", 16'h0000);
        up_to("up5_flick", 16'h003F);
        down_to("dn0e_flick", 16'h0000);
        flick = 1'b0;
        repeat (3) step("idle_after2");

        // Flick on the 0x003F / 0x07FF edges of UP15, then of UP10.
        start_seq("start3");
        up_to("up15_c", 16'h001F);
        flick = 1'b1;
        up_to("up15_at3f", 16'h003F);
        flick = 1'b0;
`ifdef BOUND_FLASHER_KICKBACK_EN
        down_to("kb0_a", 16'h0000);
        exp_led = 16'h0001;
        step("kb0_a_restart");
        up_to("up15_d", 16'h03FF);
        flick = 1'b1;
        up_to("up15_at7ff", 16'h07FF);
        flick = 1'b0;
        down_to("kb0_b", 16'h0000);
        exp_led = 16'h0001;
        step("kb0_b_restart");
        up_to("up15_e", 16'hFFFF);
        down_to("dn5_e", 16'h001F);
        up_to("up10_e", 16'h03FF);
        flick = 1'b1;
        up_to("up10_at7ff", 16'h07FF);
        flick = 1'b0;
        down_to("up10_kb_dn5", 16'h001F);
        up_to("up10_kb_up", 16'h07FF);
        down_to("dn0_e", 16'h0000);
`else
        up_to("up15_d", 16'h03FF);
        flick = 1'b1;
        up_to("up15_at7ff", 16'h07FF);
        flick = 1'b0;
        up_to("up15_e", 16'hFFFF);
        down_to("dn5_e", 16'h001F);
        up_to("up10_e", 16'h03FF);
        flick = 1'b1;
        up_to("up10_at7ff", 16'h07FF);
        flick = 1'b0;
        down_to("dn0_e", 16'h0000);
`endif
        up_to("up5_e", 16'h003F);
        down_to("dn0e_e", 16'h0000);
        repeat (3) step("idle_after3");

        // Reset mid-sequence at 0x00FF, then restart.
        start_seq("start4");
        up_to("up15_f", 16'h00FF);
        rst_n   = 1'b1;
        exp_led = 16'h0000;
        step("mid_reset");
        rst_n = 1'b0;
        step("idle_post_rst");
        step("idle_post_rst2");
        start_seq("restart");
        up_to("restart_up", 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
